// File: rtl/operand_fetch_if.sv
// Decode-to-execute pipeline handshake bundle for the operand-fetch stage.
// The slave side is the stage itself; the master side is decode plus execute.
interface operand_fetch_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);

  // Decode side
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;

  // Execute side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [ADDR_W-1:0] out_rd;
  logic              out_fault;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_fault
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_fault
  );

endinterface

// File: rtl/operand_fetch.sv
// Register-read stage: issues register-file reads, realigns the 1-cycle read
// data with the instruction, forwards writes the register file has not yet
// exposed, applies the access-key check and hands operands to execute.
module operand_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter logic [15:0] KEY    = 16'h0032
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_if.slave    pipe,
  output logic [ADDR_W-1:0] reg1,
  output logic [ADDR_W-1:0] reg2,
  input  logic [DATA_W-1:0] read_reg1,
  input  logic [DATA_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] address_mem,
  input  logic [DATA_W-1:0] write_data_mem,
  input  logic [ADDR_W-1:0] address_alu,
  input  logic [DATA_W-1:0] write_data_alu,
  input  logic [15:0]       key_access
);

  // Stage A: read in flight
  logic              a_valid_q;
  logic [ADDR_W-1:0] a_rs1_q, a_rs2_q, a_rd_q;

  // Writes presented last cycle; the registered read data does not include them
  logic [ADDR_W-1:0] pw_mem_addr_q, pw_alu_addr_q;
  logic [DATA_W-1:0] pw_mem_data_q, pw_alu_data_q;

  // Stage B: output register
  logic              b_valid_q;
  logic [DATA_W-1:0] b_op1_q, b_op2_q;
  logic [ADDR_W-1:0] b_rd_q;
  logic              b_fault_q;

  logic              a_adv;
  logic              in_fire;
  logic              fault;
  logic [DATA_W-1:0] op1, op2;

  // ALU port wins over the memory port, matching the register file's own priority
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] rs,
    input logic [DATA_W-1:0] rf_data,
    input logic [ADDR_W-1:0] alu_addr,
    input logic [DATA_W-1:0] alu_data,
    input logic [ADDR_W-1:0] mem_addr,
    input logic [DATA_W-1:0] mem_data
  );
    if (rs == '0)            return '0;
    else if (alu_addr == rs) return alu_data;
    else if (mem_addr == rs) return mem_data;
    else                     return rf_data;
  endfunction

  // Handshake, read-address steering and operand formation
  always_comb begin
    a_adv         = a_valid_q && (!b_valid_q || pipe.out_ready);
    pipe.in_ready = !a_valid_q || a_adv;
    in_fire       = pipe.in_valid && pipe.in_ready;
    // A stalled entry re-reads every cycle so late writes keep flowing in
    reg1          = in_fire ? pipe.in_rs1 : a_rs1_q;
    reg2          = in_fire ? pipe.in_rs2 : a_rs2_q;
    op1           = fwd(a_rs1_q, read_reg1, pw_alu_addr_q, pw_alu_data_q,
                        pw_mem_addr_q, pw_mem_data_q);
    op2           = fwd(a_rs2_q, read_reg2, pw_alu_addr_q, pw_alu_data_q,
                        pw_mem_addr_q, pw_mem_data_q);
    fault         = (key_access != KEY);
  end

  // Snoop both register-file write ports every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_mem_addr_q <= '0;
      pw_mem_data_q <= '0;
      pw_alu_addr_q <= '0;
      pw_alu_data_q <= '0;
    end else begin
      pw_mem_addr_q <= address_mem;
      pw_mem_data_q <= write_data_mem;
      pw_alu_addr_q <= address_alu;
      pw_alu_data_q <= write_data_alu;
    end
  end

  // Stage A: accept from decode, release when B can take the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_rs1_q   <= '0;
      a_rs2_q   <= '0;
      a_rd_q    <= '0;
    end else if (in_fire) begin
      a_valid_q <= 1'b1;
      a_rs1_q   <= pipe.in_rs1;
      a_rs2_q   <= pipe.in_rs2;
      a_rd_q    <= pipe.in_rd;
    end else if (a_adv) begin
      a_valid_q <= 1'b0;
    end
  end

  // Stage B: load from A, hold under backpressure, drop when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid_q <= 1'b0;
      b_op1_q   <= '0;
      b_op2_q   <= '0;
      b_rd_q    <= '0;
      b_fault_q <= 1'b0;
    end else if (a_adv) begin
      b_valid_q <= 1'b1;
      b_op1_q   <= fault ? '0 : op1;
      b_op2_q   <= fault ? '0 : op2;
      b_rd_q    <= a_rd_q;
      b_fault_q <= fault;
    end else if (b_valid_q && pipe.out_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  assign pipe.out_valid = b_valid_q;
  assign pipe.out_op1   = b_op1_q;
  assign pipe.out_op2   = b_op2_q;
  assign pipe.out_rd    = b_rd_q;
  assign pipe.out_fault = b_fault_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural register file drives the DUT, and a
// transaction-level model (instruction queue plus one output slot, operands
// taken from the register-file array) predicts every output.
module tb_operand_fetch;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [15:0] KEY    = 16'h0032;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] reg1, reg2, address_mem, address_alu;
  logic [DATA_W-1:0] read_reg1, read_reg2, write_data_mem, write_data_alu;
  logic [15:0]       key_access;

  operand_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .KEY(KEY)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe           (bus),
    .reg1           (reg1),
    .reg2           (reg2),
    .read_reg1      (read_reg1),
    .read_reg2      (read_reg2),
    .address_mem    (address_mem),
    .write_data_mem (write_data_mem),
    .address_alu    (address_alu),
    .write_data_alu (write_data_alu),
    .key_access     (key_access)
  );

  // Register file: registered reads, both ports written every cycle, ALU last so it wins
  logic [DATA_W-1:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= $urandom;
      read_reg1 <= '0;
      read_reg2 <= '0;
    end else begin
      read_reg1        <= rf[reg1];
      read_reg2        <= rf[reg2];
      rf[address_mem]  <= write_data_mem;
      rf[address_alu]  <= write_data_alu;
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
  } instr_t;

  instr_t      a_q[$];
  logic        b_full = 1'b0;
  logic [31:0] b_op1 = '0, b_op2 = '0;
  logic [4:0]  b_rd = '0;
  logic        b_fault = 1'b0;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural register value: x0 reads as zero
  function automatic logic [31:0] ref_op(input logic [4:0] rs);
    return (rs == 5'd0) ? 32'h0 : rf[rs];
  endfunction

  // Compare outputs against the model's output slot
  task automatic tick();
    @(negedge clk);
    check_eq("out_valid", 32'(bus.out_valid), 32'(b_full));
    if (b_full) begin
      check_eq("out_op1", bus.out_op1, b_op1);
      check_eq("out_op2", bus.out_op2, b_op2);
      check_eq("out_rd", 32'(bus.out_rd), 32'(b_rd));
      check_eq("out_fault", 32'(bus.out_fault), 32'(b_fault));
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic ordy,
                       input logic [4:0] am, input logic [31:0] dm,
                       input logic [4:0] aa, input logic [31:0] da, input logic [15:0] key);
    bus.in_valid   = iv;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.out_ready  = ordy;
    address_mem    = am;
    write_data_mem = dm;
    address_alu    = aa;
    write_data_alu = da;
    key_access     = key;
  endtask

  // Check acceptance, then advance the model across the coming edge
  task automatic settle();
    logic   exp_rdy, adv, flt;
    instr_t it;
    #1;
    exp_rdy = (a_q.size() == 0) || !b_full || bus.out_ready;
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    adv = (a_q.size() != 0) && (!b_full || bus.out_ready);
    if (adv) begin
      it      = a_q.pop_front();
      flt     = (key_access != KEY);
      b_op1   = flt ? 32'h0 : ref_op(it.rs1);
      b_op2   = flt ? 32'h0 : ref_op(it.rs2);
      b_rd    = it.rd;
      b_fault = flt;
      b_full  = 1'b1;
    end else if (b_full && bus.out_ready) begin
      b_full = 1'b0;
    end
    if (bus.in_valid && exp_rdy) a_q.push_back('{bus.in_rs1, bus.in_rs2, bus.in_rd});
  endtask

  task automatic cyc(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic ordy,
                     input logic [4:0] am, input logic [31:0] dm,
                     input logic [4:0] aa, input logic [31:0] da, input logic [15:0] key);
    tick();
    drive(iv, rs1, rs2, rd, ordy, am, dm, aa, da, key);
    settle();
  endtask

  // No instruction; writes land on x0
  task automatic idle(input logic ordy);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, ordy, 5'd0, $urandom, 5'd0, $urandom, KEY);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
    check_eq({tag, "_op1"}, bus.out_op1, 32'h0);
    check_eq({tag, "_op2"}, bus.out_op2, 32'h0);
    check_eq({tag, "_rd"}, 32'(bus.out_rd), 32'h0);
    check_eq({tag, "_fault"}, 32'(bus.out_fault), 32'h0);
  endtask

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, KEY);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Hazard-free stream: x5=0x11, x6=0x22
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6, 32'h22, 5'd5, 32'h11, KEY);
    idle(1'b1);
    cyc(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 5'd0, $urandom, 5'd0, $urandom, KEY);
    idle(1'b1);
    tick();
    check_eq("stream_op1", bus.out_op1, 32'h11);
    check_eq("stream_op2", bus.out_op2, 32'h22);
    check_eq("stream_rd", 32'(bus.out_rd), 32'd7);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, KEY);
    settle();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd5, 5'd6, 5'(8 + i), 1'b1, 5'd0, $urandom, 5'd0, $urandom, KEY);
    idle(1'b1);
    idle(1'b1);

    // Forwarding: ALU in issue cycle, ALU+mem to same reg, mem only
    cyc(1'b1, 5'd5, 5'd6, 5'd12, 1'b1, 5'd0, $urandom, 5'd5, 32'hAAAA, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd13, 1'b1, 5'd5, 32'hBBBB, 5'd5, 32'hAAAA, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd14, 1'b1, 5'd5, 32'hBBBB, 5'd0, $urandom, KEY);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: three pending, four stalled cycles, write to A-held rs1 mid-stall
    cyc(1'b1, 5'd1, 5'd2, 5'd20, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd3, 5'd4, 5'd21, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd22, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd22, 1'b0, 5'd0, $urandom, 5'd3, 32'h3333, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd22, 1'b0, 5'd4, 32'h4444, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd22, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd5, 5'd6, 5'd22, 1'b1, 5'd0, $urandom, 5'd0, $urandom, KEY);
    repeat (3) idle(1'b1);

    // x0 stays zero despite a write to it
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, $urandom, 5'd0, 32'hFFFF, KEY);
    cyc(1'b1, 5'd0, 5'd0, 5'd23, 1'b1, 5'd0, $urandom, 5'd0, 32'hFFFF, KEY);
    idle(1'b1);
    tick();
    check_eq("x0_op1", bus.out_op1, 32'h0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, KEY);
    settle();

    // Key mismatch, then key match
    cyc(1'b1, 5'd5, 5'd6, 5'd24, 1'b1, 5'd0, $urandom, 5'd0, $urandom, 16'h0033);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, $urandom, 5'd0, $urandom, 16'h0033);
    tick();
    check_eq("key_bad_fault", 32'(bus.out_fault), 32'h1);
    check_eq("key_bad_op1", bus.out_op1, 32'h0);
    check_eq("key_bad_rd", 32'(bus.out_rd), 32'd24);
    drive(1'b1, 5'd5, 5'd6, 5'd25, 1'b1, 5'd0, $urandom, 5'd0, $urandom, KEY);
    settle();
    idle(1'b1);
    tick();
    check_eq("key_ok_fault", 32'(bus.out_fault), 32'h0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0, 5'd0, 32'h0, KEY);
    settle();

    // Asynchronous reset with A and B occupied
    cyc(1'b1, 5'd1, 5'd2, 5'd26, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    cyc(1'b1, 5'd3, 5'd4, 5'd27, 1'b0, 5'd0, $urandom, 5'd0, $urandom, KEY);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, KEY);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    a_q.delete();
    b_full = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic over a narrow register window to provoke hazards
    repeat (400) begin
      cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom), $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 15) == 0) ? 16'h0033 : KEY);
    end
    repeat (4) idle(1'b1);
    tick();
    check_eq("drained", 32'(bus.out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
